nxn_game_controller: RTL and testbench
======================================

# nxn_game_controller

Parametrised turn-sequencing controller for N×N multi-player grid games; successor to the fixed 3×3 two-player controller. Accepts player moves via a valid/ready handshake, rejects illegal moves, writes legal moves to the board register, waits for the external win checker, and rotates turns until a win or a full board. Sits between the player-input front end and the board register / win-checker pair.

## Interface
- BOARD_N, 3: board side length, 3..8; cells = BOARD_N*BOARD_N
- NUM_PLAYERS, 2: players, 2..4
- TIMEOUT_CYCLES, 1024: per-turn cycle budget, ≥2; used only with TURN_TIMEOUT_EN
- Derived: AW = clog2(cells), CW = clog2(NUM_PLAYERS+1), PW = clog2(NUM_PLAYERS)
- ph1  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low
- start  in  1  begin/restart game
- first_player  in  PW  player who moves first, sampled with start
- move_valid  in  1  move offered
- move_addr  in  AW  target cell, row-major
- move_ready  out  1  controller accepts a move this cycle
- board  in  cells*CW  current board, cell i at [i*CW +: CW]
- cell_we  out  1  board write strobe
- cell_addr  out  AW  board write address
- cell_state  out  CW  code written, player p → p+1
- board_clr  out  1  one-cycle board clear request
- check_done  in  1  win checker result valid
- game_over  in  1  checker reports a win
- winner  in  CW  winning player's code
- cur_player  out  PW  player whose turn it is
- move_reject  out  1  one-cycle pulse, illegal move
- result_valid  out  1  game finished, held until start
- result  out  CW  winner code, 0 = tie
- turn_timeout  out  1  one-cycle pulse, turn forfeited

## Operation
- Cell codes: 0 = empty, player p = p+1.
- States: IDLE, TURN, WRITE, CHECK, DONE.
- Reset (reset=0 at edge): state IDLE; all outputs 0; move count 0.
- start=1 in any state: next state TURN, board_clr pulses 1 cycle, move count 0, cur_player = first_player (0 if first_player ≥ NUM_PLAYERS), result_valid/result cleared. start overrides every other event that cycle.
- TURN: move_ready=1. Handshake when move_valid && move_ready. Move legal iff move_addr < cells and board cell is 0.
  - Legal: latch addr, go WRITE.
  - Illegal: move_reject=1 next cycle, stay TURN, same player.
- WRITE: cell_we=1 for exactly one cycle, cell_addr = latched addr, cell_state = cur_player+1; increment move count; go CHECK.
- CHECK: move_ready=0; wait for check_done (checker latency unbounded; check_done in WRITE cycle ignored). On check_done:
  - game_over=1 → DONE, result = winner.
  - else move count == cells → DONE, result = 0.
  - else cur_player += 1, wraps NUM_PLAYERS-1 → 0; go TURN.
- DONE: result_valid=1, move_ready=0; leaves only on start.
- move_valid outside TURN ignored; no reject pulse.
- Move count width clog2(cells+1); saturates, never wraps.
- cell_addr/cell_state hold last written value when cell_we=0.

## Timing
- Legal move accepted at edge k: cell_we high in cycle k+1; earliest next move_ready in cycle k+3 (check_done one cycle after write).
- move_reject high in cycle k+1 after an illegal handshake at edge k; move_ready stays 1.
- result_valid rises the cycle after the terminating check_done.
- board_clr high the cycle after start sampled.
- All outputs registered except move_ready (decode of state).

## Configuration
- TURN_TIMEOUT_EN defined: timer counts cycles in TURN, cleared on entering TURN or on any handshake. Reaching TIMEOUT_CYCLES-1 without a legal move: turn_timeout pulses 1 cycle, cur_player advances (wrap), stay TURN, move count unchanged. A legal handshake in the expiry cycle wins; no timeout.
- Undefined: no timer logic; turn_timeout tied 0; TIMEOUT_CYCLES ignored.

## Structure
- game_pkg: state enum, CELL_EMPTY constant, player-to-code and code-to-player functions.
- One sub-module: turn_timer (counter, clear, expiry pulse), instantiated only under TURN_TIMEOUT_EN.

## Test plan
- N=3, P=2, start first_player=1; moves 0,3,1,4,2 with checker game_over on 5th, winner=2 → cell_state 2,1,2,1,2; result_valid=1, result=2.
- N=3: nine legal moves, checker never game_over → result=0 after 9th check_done, result_valid=1.
- Move to occupied cell 4, then to addr 9 (N=3) → two move_reject pulses, cur_player unchanged, no cell_we.
- N=4, P=3, first_player=2 → cur_player sequence 2,0,1,2; cell_state 3,1,2,3.
- start asserted during CHECK → board_clr pulse, state TURN, move count 0, stale check_done ignored.
- TURN_TIMEOUT_EN, TIMEOUT_CYCLES=8: idle 8 cycles → turn_timeout pulse, cur_player 0→1; move_valid on expiry cycle → accepted, no timeout.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the N x N game controller.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_e;

  // Widest codes needed for up to 4 players (codes 0..4, players 0..3).
  localparam int CODE_MAX_W   = 3;
  localparam int PLAYER_MAX_W = 2;

  localparam logic [CODE_MAX_W-1:0] CELL_EMPTY = '0;

  // Player p is stored on the board as p+1; 0 means empty.
  function automatic logic [CODE_MAX_W-1:0] player_to_code(input logic [PLAYER_MAX_W-1:0] p);
    return {1'b0, p} + CODE_MAX_W'(1);
  endfunction

  function automatic logic [PLAYER_MAX_W-1:0] code_to_player(input logic [CODE_MAX_W-1:0] c);
    logic [CODE_MAX_W-1:0] p;
    p = c - CODE_MAX_W'(1);
    return p[PLAYER_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/nxn_game_controller_turn_timer.sv
// Per-turn cycle counter: counts while run is high, restarts on clr,
// flags expiry when the count reaches TIMEOUT_CYCLES-1.
module turn_timer
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic ph1,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == LAST);

  // Next count: idle or cleared holds zero, otherwise count up and stick at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run)       cnt_d = '0;
    else if (cnt_q != LAST) cnt_d = cnt_q + TW'(1);
  end

  // Count register.
  always_ff @(posedge ph1) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nxn_game_controller.sv
// Turn sequencer for N x N multi-player grid games: accepts moves, rejects
// illegal ones, writes legal ones to the board, waits for the win checker and
// rotates turns until a win or a full board.
// Optional per-turn timeout enabled by defining TURN_TIMEOUT_EN.
module nxn_game_controller
  import game_pkg::*;
#(
  parameter int BOARD_N        = 3,
  parameter int NUM_PLAYERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CELLS = BOARD_N * BOARD_N,
  localparam int AW    = $clog2(CELLS),
  localparam int CW    = $clog2(NUM_PLAYERS + 1),
  localparam int PW    = $clog2(NUM_PLAYERS),
  localparam int MW    = $clog2(CELLS + 1)
) (
  input  logic                ph1,
  input  logic                reset,
  input  logic                start,
  input  logic [PW-1:0]       first_player,
  input  logic                move_valid,
  input  logic [AW-1:0]       move_addr,
  output logic                move_ready,
  input  logic [CELLS*CW-1:0] board,
  output logic                cell_we,
  output logic [AW-1:0]       cell_addr,
  output logic [CW-1:0]       cell_state,
  output logic                board_clr,
  input  logic                check_done,
  input  logic                game_over,
  input  logic [CW-1:0]       winner,
  output logic [PW-1:0]       cur_player,
  output logic                move_reject,
  output logic                result_valid,
  output logic [CW-1:0]       result,
  output logic                turn_timeout
);

  state_e        state_q, state_d;
  logic [PW-1:0] cur_q, cur_d, cur_next, fp_sel;
  logic [MW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cst_q, cst_d, res_q, res_d;
  logic          we_q, we_d, clr_q, clr_d, rej_q, rej_d, to_q, to_d, rv_q, rv_d;
  logic          hs, legal_hs, addr_hit, occupied, timeout_fire;

  assign move_ready = (state_q == S_TURN);
  assign hs         = move_valid && move_ready;
  assign legal_hs   = hs && addr_hit && !occupied;
  assign cur_next   = (cur_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_q + PW'(1);

  // Out-of-range first player only possible when NUM_PLAYERS is not a power of two.
  if ((1 << PW) > NUM_PLAYERS) begin : g_fp_clamp
    assign fp_sel = (int'(first_player) < NUM_PLAYERS) ? first_player : '0;
  end else begin : g_fp_pass
    assign fp_sel = first_player;
  end

`ifdef TURN_TIMEOUT_EN
  logic tmr_expired;

  // Timer restarts on a new game, on any handshake and on each forfeited turn.
  turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_turn_timer (
    .ph1     (ph1),
    .reset   (reset),
    .run     (state_q == S_TURN),
    .clr     (start || hs || timeout_fire),
    .expired (tmr_expired)
  );

  // A legal move in the expiry cycle takes precedence over the forfeit.
  assign timeout_fire = tmr_expired && !legal_hs;
`else
  assign timeout_fire = 1'b0;
`endif

  // Decode the target cell: in range, and whether someone already owns it.
  always_comb begin
    addr_hit = 1'b0;
    occupied = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (move_addr == AW'(i)) begin
        addr_hit = 1'b1;
        occupied = (board[i*CW +: CW] != CW'(CELL_EMPTY));
      end
    end
  end

  // Next-state and registered-output logic; start overrides everything.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    cst_d   = cst_q;
    res_d   = res_q;
    rv_d    = rv_q;
    we_d    = 1'b0;
    clr_d   = 1'b0;
    rej_d   = 1'b0;
    to_d    = 1'b0;
    if (start) begin
      state_d = S_TURN;
      clr_d   = 1'b1;
      cnt_d   = '0;
      cur_d   = fp_sel;
      rv_d    = 1'b0;
      res_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_TURN: begin
          if (legal_hs) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = move_addr;
            cst_d   = CW'(player_to_code(PLAYER_MAX_W'(cur_q)));
          end else begin
            if (hs) rej_d = 1'b1;
            if (timeout_fire) begin
              to_d  = 1'b1;
              cur_d = cur_next;
            end
          end
        end
        S_WRITE: begin
          if (cnt_q != '1) cnt_d = cnt_q + MW'(1);
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (check_done) begin
            if (game_over) begin
              state_d = S_DONE;
              rv_d    = 1'b1;
              res_d   = winner;
            end else if (cnt_q == MW'(CELLS)) begin
              state_d = S_DONE;
              rv_d    = 1'b1;
              res_d   = '0;
            end else begin
              state_d = S_TURN;
              cur_d   = cur_next;
            end
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      cst_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      we_q    <= 1'b0;
      clr_q   <= 1'b0;
      rej_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cst_q   <= cst_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      we_q    <= we_d;
      clr_q   <= clr_d;
      rej_q   <= rej_d;
      to_q    <= to_d;
    end
  end

  assign cell_we      = we_q;
  assign cell_addr    = addr_q;
  assign cell_state   = cst_q;
  assign board_clr    = clr_q;
  assign cur_player   = cur_q;
  assign move_reject  = rej_q;
  assign result_valid = rv_q;
  assign result       = res_q;
  assign turn_timeout = to_q;

endmodule

// File: tb/tb_nxn_game_controller.sv
// Bench for nxn_game_controller: instance 0 is 3x3 / 2 players, instance 1 is
// 4x4 / 3 players. The bench plays both the players and the win checker and
// keeps its own board, turn and move-count model.
module tb_nxn_game_controller;

  localparam int TO = 8;

  logic ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  logic       reset;
  logic       start_i [2];
  logic       mv_i    [2];
  logic       cd_i    [2];
  logic       fp0;
  logic [1:0] fp1;
  logic [3:0] move_addr;
  logic       game_over;
  logic [1:0] winner;
  logic [17:0] board0;
  logic [31:0] board1;

  logic       rdy0, rdy1, we0, we1, clr0, clr1, rej0, rej1, rv0, rv1, to0, to1, cur0;
  logic [3:0] ca0, ca1;
  logic [1:0] cs0, cs1, res0, res1, cur1;

  logic       ready_o [2], we_o [2], clr_o [2], rej_o [2], rv_o [2], to_o [2];
  logic [3:0] addr_o  [2];
  logic [1:0] cst_o [2], res_o [2], cur_o [2];

  logic [1:0] brd [2][16];
  int cur_m [2];
  int cnt_m [2];
  int total = 0;
  int bad   = 0;

  nxn_game_controller #(.BOARD_N(3), .NUM_PLAYERS(2), .TIMEOUT_CYCLES(TO)) dut0 (
    .ph1(ph1), .reset(reset), .start(start_i[0]), .first_player(fp0),
    .move_valid(mv_i[0]), .move_addr(move_addr), .move_ready(rdy0), .board(board0),
    .cell_we(we0), .cell_addr(ca0), .cell_state(cs0), .board_clr(clr0),
    .check_done(cd_i[0]), .game_over(game_over), .winner(winner), .cur_player(cur0),
    .move_reject(rej0), .result_valid(rv0), .result(res0), .turn_timeout(to0));

  nxn_game_controller #(.BOARD_N(4), .NUM_PLAYERS(3), .TIMEOUT_CYCLES(TO)) dut1 (
    .ph1(ph1), .reset(reset), .start(start_i[1]), .first_player(fp1),
    .move_valid(mv_i[1]), .move_addr(move_addr), .move_ready(rdy1), .board(board1),
    .cell_we(we1), .cell_addr(ca1), .cell_state(cs1), .board_clr(clr1),
    .check_done(cd_i[1]), .game_over(game_over), .winner(winner), .cur_player(cur1),
    .move_reject(rej1), .result_valid(rv1), .result(res1), .turn_timeout(to1));

  always_comb begin
    ready_o[0] = rdy0; ready_o[1] = rdy1;
    we_o[0]    = we0;  we_o[1]    = we1;
    clr_o[0]   = clr0; clr_o[1]   = clr1;
    rej_o[0]   = rej0; rej_o[1]   = rej1;
    rv_o[0]    = rv0;  rv_o[1]    = rv1;
    to_o[0]    = to0;  to_o[1]    = to1;
    addr_o[0]  = ca0;  addr_o[1]  = ca1;
    cst_o[0]   = cs0;  cst_o[1]   = cs1;
    res_o[0]   = res0; res_o[1]   = res1;
    cur_o[0]   = {1'b0, cur0};
    cur_o[1]   = cur1;
  end

  // The bench acts as the board register, presenting its model board.
  always_comb begin
    board0 = '0;
    board1 = '0;
    for (int i = 0; i < 9; i++)  board0[i*2 +: 2] = brd[0][i];
    for (int i = 0; i < 16; i++) board1[i*2 +: 2] = brd[1][i];
  end

  function automatic int ncells(input int d);
    return (d != 0) ? 16 : 9;
  endfunction

  function automatic int nplay(input int d);
    return (d != 0) ? 3 : 2;
  endfunction

  task automatic do_start(input int d, input int fp);
    if (d == 0) fp0 = fp[0]; else fp1 = fp[1:0];
    start_i[d] = 1'b1;
    @(negedge ph1);
    start_i[d] = 1'b0;
    for (int i = 0; i < 16; i++) brd[d][i] = 2'd0;
    cnt_m[d] = 0;
    cur_m[d] = (fp < nplay(d)) ? fp : 0;
    total++;
    if (clr_o[d] !== 1'b1 || ready_o[d] !== 1'b1 || cur_o[d] !== 2'(cur_m[d]) ||
        rv_o[d] !== 1'b0 || res_o[d] !== 2'd0 || we_o[d] !== 1'b0) begin
      bad++;
      $display("FAIL start d=%0d clr=%b ready=%b cur=%0d rv=%b res=%0d we=%b want clr=1 ready=1 cur=%0d rv=0 res=0 we=0",
               d, clr_o[d], ready_o[d], cur_o[d], rv_o[d], res_o[d], we_o[d], cur_m[d]);
    end
  endtask

  // One player move plus the checker response; ended reports game over per the model.
  task automatic do_move(input int d, input int addr, input bit over, input int win,
                         input int dly, output bit ended);
    bit legal;
    int exp_res;
    ended = 1'b0;
    exp_res = 0;
    legal = (addr < ncells(d)) && (brd[d][addr] == 2'd0);
    total++;
    if (ready_o[d] !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_move d=%0d got=%b want=1", d, ready_o[d]);
    end
    mv_i[d] = 1'b1;
    move_addr = 4'(addr);
    @(negedge ph1);
    mv_i[d] = 1'b0;
    if (!legal) begin
      total++;
      if (rej_o[d] !== 1'b1 || we_o[d] !== 1'b0 || ready_o[d] !== 1'b1 || cur_o[d] !== 2'(cur_m[d])) begin
        bad++;
        $display("FAIL reject d=%0d addr=%0d rej=%b we=%b ready=%b cur=%0d want rej=1 we=0 ready=1 cur=%0d",
                 d, addr, rej_o[d], we_o[d], ready_o[d], cur_o[d], cur_m[d]);
      end
      @(negedge ph1);
      total++;
      if (rej_o[d] !== 1'b0) begin
        bad++;
        $display("FAIL reject_pulse d=%0d rej=%b want 0", d, rej_o[d]);
      end
      return;
    end
    total++;
    if (we_o[d] !== 1'b1 || rej_o[d] !== 1'b0 || to_o[d] !== 1'b0 ||
        addr_o[d] !== 4'(addr) || cst_o[d] !== 2'(cur_m[d] + 1)) begin
      bad++;
      $display("FAIL write d=%0d we=%b rej=%b to=%b addr=%0d state=%0d want we=1 rej=0 to=0 addr=%0d state=%0d",
               d, we_o[d], rej_o[d], to_o[d], addr_o[d], cst_o[d], addr, cur_m[d] + 1);
    end
    brd[d][addr] = 2'(cur_m[d] + 1);
    cnt_m[d]++;
    // A checker pulse during the write cycle must be ignored.
    cd_i[d] = 1'b1; game_over = 1'b1; winner = 2'd1;
    @(negedge ph1);
    cd_i[d] = 1'b0; game_over = 1'b0;
    total++;
    if (ready_o[d] !== 1'b0 || we_o[d] !== 1'b0 || rv_o[d] !== 1'b0) begin
      bad++;
      $display("FAIL check_wait d=%0d ready=%b we=%b rv=%b want 0 0 0", d, ready_o[d], we_o[d], rv_o[d]);
    end
    for (int i = 0; i < dly; i++) begin
      mv_i[d] = 1'b1;
      move_addr = 4'($urandom_range(0, 15));
      @(negedge ph1);
      total++;
      if (we_o[d] !== 1'b0 || rej_o[d] !== 1'b0 || ready_o[d] !== 1'b0) begin
        bad++;
        $display("FAIL busy_ignore d=%0d we=%b rej=%b ready=%b want 0 0 0", d, we_o[d], rej_o[d], ready_o[d]);
      end
    end
    mv_i[d] = 1'b0;
    cd_i[d] = 1'b1; game_over = over; winner = 2'(win);
    @(negedge ph1);
    cd_i[d] = 1'b0; game_over = 1'b0;
    if (over) begin
      ended = 1'b1; exp_res = win;
    end else if (cnt_m[d] == ncells(d)) begin
      ended = 1'b1; exp_res = 0;
    end else begin
      cur_m[d] = (cur_m[d] + 1) % nplay(d);
    end
    total++;
    if (ended) begin
      if (rv_o[d] !== 1'b1 || res_o[d] !== 2'(exp_res) || ready_o[d] !== 1'b0) begin
        bad++;
        $display("FAIL game_end d=%0d rv=%b res=%0d ready=%b want rv=1 res=%0d ready=0",
                 d, rv_o[d], res_o[d], ready_o[d], exp_res);
      end
    end else if (rv_o[d] !== 1'b0 || ready_o[d] !== 1'b1 || cur_o[d] !== 2'(cur_m[d])) begin
      bad++;
      $display("FAIL next_turn d=%0d rv=%b ready=%b cur=%0d want rv=0 ready=1 cur=%0d",
               d, rv_o[d], ready_o[d], cur_o[d], cur_m[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fp0 = 1'b0; fp1 = 2'd0; move_addr = '0; game_over = 1'b0; winner = '0;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 1'b0; mv_i[d] = 1'b0; cd_i[d] = 1'b0;
      cur_m[d] = 0; cnt_m[d] = 0;
      for (int i = 0; i < 16; i++) brd[d][i] = 2'd0;
    end
    repeat (3) @(negedge ph1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({ready_o[d], we_o[d], clr_o[d], rej_o[d], rv_o[d], to_o[d]} !== 6'b0 ||
          addr_o[d] !== 4'd0 || cst_o[d] !== 2'd0 || res_o[d] !== 2'd0 || cur_o[d] !== 2'd0) begin
        bad++;
        $display("FAIL reset d=%0d ready=%b we=%b clr=%b rej=%b rv=%b to=%b addr=%0d state=%0d res=%0d cur=%0d want all 0",
                 d, ready_o[d], we_o[d], clr_o[d], rej_o[d], rv_o[d], to_o[d], addr_o[d], cst_o[d], res_o[d], cur_o[d]);
      end
    end
    reset = 1'b1;
    @(negedge ph1);
  endtask

  task automatic test_win_n3();
    int seq [5];
    bit e;
    seq = '{0, 3, 1, 4, 2};
    do_start(0, 1);
    for (int i = 0; i < 5; i++) do_move(0, seq[i], (i == 4), 2, i % 3, e);
    // Moves in DONE are ignored and the result is held.
    mv_i[0] = 1'b1; move_addr = 4'd5;
    repeat (3) begin
      @(negedge ph1);
      total++;
      if (rv_o[0] !== 1'b1 || res_o[0] !== 2'd2 || we_o[0] !== 1'b0 || rej_o[0] !== 1'b0 || ready_o[0] !== 1'b0) begin
        bad++;
        $display("FAIL done_hold rv=%b res=%0d we=%b rej=%b ready=%b want rv=1 res=2 we=0 rej=0 ready=0",
                 rv_o[0], res_o[0], we_o[0], rej_o[0], ready_o[0]);
      end
    end
    mv_i[0] = 1'b0;
  endtask

  task automatic test_illegal();
    bit e;
    do_start(0, 0);
    do_move(0, 4, 1'b0, 0, 0, e);
    do_move(0, 4, 1'b0, 0, 0, e);
    do_move(0, 9, 1'b0, 0, 0, e);
    do_move(0, 15, 1'b0, 0, 0, e);
    do_move(0, 8, 1'b0, 0, 1, e);
  endtask

  task automatic test_n4_rotation();
    bit e;
    do_start(1, 2);
    for (int i = 0; i < 4; i++) do_move(1, i, 1'b0, 0, $urandom_range(0, 2), e);
    do_start(1, 3);
  endtask

  task automatic test_start_in_check();
    do_start(0, 1);
    mv_i[0] = 1'b1; move_addr = 4'd0;
    @(negedge ph1);
    mv_i[0] = 1'b0;
    @(negedge ph1);
    // In CHECK: restart while the checker reports a win in the same cycle.
    fp0 = 1'b0; start_i[0] = 1'b1;
    cd_i[0] = 1'b1; game_over = 1'b1; winner = 2'd1;
    @(negedge ph1);
    start_i[0] = 1'b0;
    for (int i = 0; i < 16; i++) brd[0][i] = 2'd0;
    cnt_m[0] = 0; cur_m[0] = 0;
    total++;
    if (clr_o[0] !== 1'b1 || ready_o[0] !== 1'b1 || rv_o[0] !== 1'b0 || cur_o[0] !== 2'd0 || we_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL start_in_check clr=%b ready=%b rv=%b cur=%0d we=%b want 1 1 0 0 0",
               clr_o[0], ready_o[0], rv_o[0], cur_o[0], we_o[0]);
    end
    @(negedge ph1);
    cd_i[0] = 1'b0; game_over = 1'b0;
    total++;
    if (clr_o[0] !== 1'b0 || ready_o[0] !== 1'b1 || rv_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL stale_check clr=%b ready=%b rv=%b want 0 1 0", clr_o[0], ready_o[0], rv_o[0]);
    end
  endtask

  task automatic test_tie(input int d, input bit fresh);
    int perm [16];
    int n, j, t;
    bit e;
    n = ncells(d);
    if (fresh) do_start(d, $urandom_range(0, nplay(d) - 1));
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = n - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < n; i++) do_move(d, perm[i], 1'b0, 0, $urandom_range(0, 2), e);
    total++;
    if (e !== 1'b1 || rv_o[d] !== 1'b1 || res_o[d] !== 2'd0) begin
      bad++;
      $display("FAIL tie d=%0d model_end=%b rv=%b res=%0d want rv=1 res=0", d, e, rv_o[d], res_o[d]);
    end
  endtask

  task automatic test_random();
    int fq [$];
    int addr;
    bit e;
    for (int g = 0; g < 8; g++) begin
      int d;
      d = g % 2;
      do_start(d, $urandom_range(0, (d != 0) ? 3 : 1));
      e = 1'b0;
      for (int it = 0; it < 200 && !e; it++) begin
        if ($urandom_range(0, 3) == 0) begin
          addr = $urandom_range(0, 15);
        end else begin
          fq.delete();
          for (int i = 0; i < ncells(d); i++) if (brd[d][i] == 2'd0) fq.push_back(i);
          addr = fq[$urandom_range(0, fq.size() - 1)];
        end
        do_move(d, addr, ($urandom_range(0, 7) == 0), $urandom_range(1, nplay(d)),
                $urandom_range(0, 3), e);
      end
    end
  endtask

  task automatic test_timeout();
    bit e;
`ifdef TURN_TIMEOUT_EN
    do_start(0, 0);
    repeat (7) @(negedge ph1);
    total++;
    if (to_o[0] !== 1'b0 || cur_o[0] !== 2'd0) begin
      bad++;
      $display("FAIL timeout_early to=%b cur=%0d want to=0 cur=0", to_o[0], cur_o[0]);
    end
    @(negedge ph1);
    cur_m[0] = 1;
    total++;
    if (to_o[0] !== 1'b1 || cur_o[0] !== 2'd1 || ready_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL timeout_fire to=%b cur=%0d ready=%b want to=1 cur=1 ready=1", to_o[0], cur_o[0], ready_o[0]);
    end
    @(negedge ph1);
    total++;
    if (to_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse to=%b want 0", to_o[0]);
    end
    // A legal move in the expiry cycle is accepted and no forfeit happens.
    do_start(0, 0);
    repeat (7) @(negedge ph1);
    do_move(0, 4, 1'b0, 0, 0, e);
`else
    do_start(0, 0);
    repeat (12) begin
      @(negedge ph1);
      total++;
      if (to_o[0] !== 1'b0 || cur_o[0] !== 2'd0 || ready_o[0] !== 1'b1) begin
        bad++;
        $display("FAIL no_timeout to=%b cur=%0d ready=%b want to=0 cur=0 ready=1", to_o[0], cur_o[0], ready_o[0]);
      end
    end
    do_move(0, 4, 1'b0, 0, 0, e);
`endif
  endtask

  initial begin
    test_reset();
    test_win_n3();
    test_illegal();
    test_n4_rotation();
    test_start_in_check();
    test_tie(0, 1'b0);
    test_tie(1, 1'b1);
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
